// File: rtl/regfile_mp.sv
// ----------------------------------------------------------------------------
// regfile_mp -- multi-port register file with write forwarding, a per-register
// pending scoreboard and a registered half-word debug readout.
//
// Ports:
//   clk                 sole clock, all state changes on the rising edge
//   reset               asynchronous active-low reset
//   we0/waddr0/wdata0   write port 0
//   we1/waddr1/wdata1   write port 1 (wins over port 0 on the same index)
//   raddr  [NREAD*AW]   packed read indices, port i at [i*AW +: AW]
//   rdata  [NREAD*W]    packed combinational read data, port i at [i*W +: W]
//   rready [NREAD]      read operand valid (register not pending)
//   sb_set/sb_addr      mark a register pending when its producer issues
//   busy   [NUM]        pending bit per register (bit 0 tied low)
//   dbg_sel/dbg_hi      debug register and half select
//   dbg_data [W/2]      registered debug readout, one cycle latency
// ----------------------------------------------------------------------------
module regfile_mp #(
    parameter int          WIDTH      = 32,
    parameter int          ADDR_WIDTH = 5,
    parameter int          NUM        = 32,
    parameter int          NREAD      = 2,
    parameter int          BYPASS     = 1,
    parameter int          GP_IDX     = 28,
    parameter logic [31:0] GP_INIT    = 32'h0000_1800,
    parameter int          SP_IDX     = 29,
    parameter logic [31:0] SP_INIT    = 32'h0000_2ffe
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        we0,
    input  logic [ADDR_WIDTH-1:0]       waddr0,
    input  logic [WIDTH-1:0]            wdata0,
    input  logic                        we1,
    input  logic [ADDR_WIDTH-1:0]       waddr1,
    input  logic [WIDTH-1:0]            wdata1,
    input  logic [NREAD*ADDR_WIDTH-1:0] raddr,
    output logic [NREAD*WIDTH-1:0]      rdata,
    output logic [NREAD-1:0]            rready,
    input  logic                        sb_set,
    input  logic [ADDR_WIDTH-1:0]       sb_addr,
    output logic [NUM-1:0]              busy,
    input  logic [ADDR_WIDTH-1:0]       dbg_sel,
    input  logic                        dbg_hi,
    output logic [WIDTH/2-1:0]          dbg_data
);

    localparam int HALF = WIDTH / 2;

    logic [WIDTH-1:0] mem_q [NUM];
    logic [WIDTH-1:0] mem_d [NUM];
    logic [NUM-1:0]   busy_q, busy_d;
    logic [HALF-1:0]  dbg_q, dbg_d;
    logic [WIDTH-1:0] dbg_word;

    function automatic logic [WIDTH-1:0] rst_val(input int idx);
        if (idx == GP_IDX)      return WIDTH'(GP_INIT);
        else if (idx == SP_IDX) return WIDTH'(SP_INIT);
        else                    return '0;
    endfunction

    // Next state. Indices >= NUM never match a loop index, so out-of-range
    // writes and scoreboard sets fall away naturally. Port 1 is applied after
    // port 0 so it wins a same-index collision, and sb_set is applied last so
    // a newly issued producer keeps the register pending.
    always_comb begin
        for (int j = 0; j < NUM; j++) begin
            mem_d[j]  = mem_q[j];
            busy_d[j] = busy_q[j];
            if (j == 0) begin
                mem_d[j]  = '0;
                busy_d[j] = 1'b0;
            end else begin
                if (we0 && waddr0 == ADDR_WIDTH'(j)) begin
                    mem_d[j]  = wdata0;
                    busy_d[j] = 1'b0;
                end
                if (we1 && waddr1 == ADDR_WIDTH'(j)) begin
                    mem_d[j]  = wdata1;
                    busy_d[j] = 1'b0;
                end
                if (sb_set && sb_addr == ADDR_WIDTH'(j)) begin
                    busy_d[j] = 1'b1;
                end
            end
        end
    end

    // Debug readout always shows stored state, never forwarded write data.
    always_comb begin
        dbg_word = '0;
        for (int j = 1; j < NUM; j++) begin
            if (dbg_sel == ADDR_WIDTH'(j)) dbg_word = mem_q[j];
        end
        dbg_d = dbg_hi ? dbg_word[HALF +: HALF] : dbg_word[HALF-1:0];
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int j = 0; j < NUM; j++) mem_q[j] <= rst_val(j);
            busy_q <= '0;
            dbg_q  <= '0;
        end else begin
            for (int j = 0; j < NUM; j++) mem_q[j] <= mem_d[j];
            busy_q <= busy_d;
            dbg_q  <= dbg_d;
        end
    end

    assign busy     = busy_q;
    assign dbg_data = dbg_q;

    // Read ports: index 0 and out-of-range indices return 0 and are always
    // ready. A forwarded write also makes the operand ready, since the value
    // being presented is the one the pending producer is delivering now.
    for (genvar gi = 0; gi < NREAD; gi++) begin : g_rd
        logic [ADDR_WIDTH-1:0] ra;
        logic [WIDTH-1:0]      val;
        logic                  rdy;

        assign ra = raddr[gi*ADDR_WIDTH +: ADDR_WIDTH];

        always_comb begin
            val = '0;
            rdy = 1'b1;
            for (int j = 1; j < NUM; j++) begin
                if (ra == ADDR_WIDTH'(j)) begin
                    val = mem_q[j];
                    rdy = !busy_q[j];
                    if (BYPASS != 0) begin
                        if (we0 && waddr0 == ra) begin
                            val = wdata0;
                            rdy = 1'b1;
                        end
                        if (we1 && waddr1 == ra) begin
                            val = wdata1;
                            rdy = 1'b1;
                        end
                    end
                end
            end
        end

        assign rdata[gi*WIDTH +: WIDTH] = val;
        assign rready[gi]               = rdy;
    end

endmodule
